// File: rtl/sha256_pkg.sv
// sha256_pkg: shared types and helpers for the SHA-256 message padder.
//   word_t       32-bit message word
//   block_t      16 words; packed [0:15] so word 0 lands in the top 32 bits
//   pad_state_e  padder control states
//   PAD_WORD     the single '1' bit that follows the message
//   num_blocks() number of 512-bit blocks for a message of `words` 32-bit words
package sha256_pkg;

    typedef logic [31:0] word_t;

    // Packed with an ascending range: element 0 is the most significant word.
    typedef word_t [0:15] block_t;

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StHold,
        StDone
    } pad_state_e;

    localparam word_t PAD_WORD = 32'h8000_0000;

    // ceil((L + 65) / 512), L = words * 32: message, the 1 bit and the 64-bit length.
    function automatic int unsigned num_blocks(input int unsigned words);
        return (words * 32 + 65 + 511) / 512;
    endfunction

endpackage

// File: rtl/sha256_block_buf.sv
// sha256_block_buf: one 512-bit block staging buffer.
//   clk_i      clock
//   rst_i      synchronous active-high reset; clears data and the full flag
//   clr_i      block consumed; drops the full flag (data is left in place)
//   we_i       write strobe for word widx_i
//   widx_i     word index 0..15
//   wdata_i    word to store
//   rdata_o    flattened block, word 0 in bits [511:480]
//   full_o     set once word 15 has been written, until clr_i
module sha256_block_buf
    import sha256_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         we_i,
    input  logic [3:0]   widx_i,
    input  word_t        wdata_i,
    output logic [511:0] rdata_o,
    output logic         full_o
);

    block_t mem_q;
    logic   full_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (we_i) begin
                mem_q[widx_i] <= wdata_i;
            end
            // Words arrive in slot order, so the write of word 15 completes the block.
            if (clr_i) begin
                full_q <= 1'b0;
            end else if (we_i && (widx_i == 4'd15)) begin
                full_q <= 1'b1;
            end
        end
    end

    assign rdata_o = mem_q;
    assign full_o  = full_q;

endmodule

// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: reads NUM_OF_WORDS message words from memory, appends SHA-256
// padding and hands out 512-bit blocks over a valid/ready handshake.
//   clk_i               clock (memory shares it)
//   rst_i               synchronous active-high reset; aborts any message in flight
//   start_i             one-cycle pulse in idle; latches input_addr_i
//   input_addr_i        word address of message word 0
//   memory_addr_o       read address (holds its last value when memory_rd_o is low)
//   memory_rd_o         read strobe, high only for real message words
//   memory_read_data_i  data for the address presented in the previous cycle
//   blk_data_o          current block, word 0 in bits [511:480]
//   blk_valid_o         blk_data_o holds a complete block
//   blk_last_o          with blk_valid_o: final block of the message
//   blk_ready_i         consumer accepts the block
//   busy_o              message in progress
//   done_o              one-cycle pulse after the last block is taken
// Build option SHA256_PAD_DBUF_EN: adds a second block buffer so the next block is
// fetched while the current one waits for the consumer.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter int unsigned MEM_LAT      = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [15:0]  input_addr_i,
    output logic [15:0]  memory_addr_o,
    output logic         memory_rd_o,
    input  logic [31:0]  memory_read_data_i,
    output logic [511:0] blk_data_o,
    output logic         blk_valid_o,
    output logic         blk_last_o,
    input  logic         blk_ready_i,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned NumBlk   = num_blocks(NUM_OF_WORDS);
    localparam logic [15:0] MsgWords = 16'(NUM_OF_WORDS);
    localparam logic [15:0] LenGIdx  = 16'(16 * NumBlk - 1);
    localparam logic [7:0]  NumBlk8  = 8'(NumBlk);
    localparam logic [7:0]  LastBlk  = 8'(NumBlk - 1);
    localparam word_t       LenBits  = 32'(NUM_OF_WORDS * 32);

    if (MEM_LAT != 1 || NUM_OF_WORDS < 1 || NUM_OF_WORDS > 2046) begin : g_bad_cfg
        $error("sha256_msg_padder: unsupported MEM_LAT or NUM_OF_WORDS");
    end

    pad_state_e state_q, state_d;

    logic        start_ok;
    logic        xfer;

    // Fill engine: walks global word index g = 16*fill_blk + fill_slot.
    logic [15:0] base_q;
    logic [15:0] addr_hold_q;
    logic [7:0]  fill_blk_q;
    logic [3:0]  fill_slot_q;
    logic [15:0] g_idx;
    logic [15:0] rd_addr;
    logic        fill_more;
    logic        issue;
    logic        is_msg;
    word_t       pad_word;

    // Capture stage: one cycle behind the issued slot, matching memory latency.
    logic        cap_valid_q;
    logic [3:0]  cap_idx_q;
    logic        cap_mem_q;
    word_t       cap_const_q;
    word_t       cap_data;
    logic        wr_last;

    logic [7:0]  out_blk_q;

    // Buffer status seen by the fill engine and the output FSM.
    logic        wr_full;       // buffer targeted by the fill engine is occupied
    logic        rd_full;       // buffer at the output holds a complete block
    logic        rd_fills_now;  // output buffer receives its final word this cycle
    logic        next_ready;    // following block is (or becomes) complete at transfer

    assign start_ok = (state_q == StIdle) && start_i;
    assign xfer     = blk_valid_o && blk_ready_i;

    assign g_idx     = {4'b0000, fill_blk_q, fill_slot_q};
    assign rd_addr   = base_q + g_idx;
    assign fill_more = fill_blk_q < NumBlk8;
    assign is_msg    = g_idx < MsgWords;

    // A new block may only begin once the previous block's last word is captured
    // and the destination buffer has been released.
    assign issue = busy_o && fill_more &&
                   ((fill_slot_q != 4'd0) || (!cap_valid_q && !wr_full));

    assign memory_rd_o   = issue && is_msg;
    assign memory_addr_o = memory_rd_o ? rd_addr : addr_hold_q;

    always_comb begin
        pad_word = '0;
        if (g_idx == MsgWords) begin
            pad_word = PAD_WORD;
        end else if (g_idx == LenGIdx) begin
            pad_word = LenBits;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            base_q      <= '0;
            addr_hold_q <= '0;
            fill_blk_q  <= '0;
            fill_slot_q <= '0;
            cap_valid_q <= 1'b0;
            cap_idx_q   <= '0;
            cap_mem_q   <= 1'b0;
            cap_const_q <= '0;
        end else begin
            if (start_ok) begin
                base_q      <= input_addr_i;
                fill_blk_q  <= '0;
                fill_slot_q <= '0;
            end else if (issue) begin
                fill_slot_q <= fill_slot_q + 4'd1;
                if (fill_slot_q == 4'd15) begin
                    fill_blk_q <= fill_blk_q + 8'd1;
                end
            end
            cap_valid_q <= issue;
            if (issue) begin
                cap_idx_q   <= fill_slot_q;
                cap_mem_q   <= is_msg;
                cap_const_q <= pad_word;
            end
            if (memory_rd_o) begin
                addr_hold_q <= rd_addr;
            end
        end
    end

    assign cap_data = cap_mem_q ? memory_read_data_i : cap_const_q;
    assign wr_last  = cap_valid_q && (cap_idx_q == 4'd15);

    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            out_blk_q <= '0;
        end else if (xfer) begin
            out_blk_q <= out_blk_q + 8'd1;
        end
    end

`ifdef SHA256_PAD_DBUF_EN
    logic         wr_sel_q;
    logic         rd_sel_q;
    logic [511:0] data0, data1;
    logic         full0, full1;

    sha256_block_buf u_buf0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (xfer && !rd_sel_q),
        .we_i    (cap_valid_q && !wr_sel_q),
        .widx_i  (cap_idx_q),
        .wdata_i (cap_data),
        .rdata_o (data0),
        .full_o  (full0)
    );

    sha256_block_buf u_buf1 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (xfer && rd_sel_q),
        .we_i    (cap_valid_q && wr_sel_q),
        .widx_i  (cap_idx_q),
        .wdata_i (cap_data),
        .rdata_o (data1),
        .full_o  (full1)
    );

    // Fill and output sides ping-pong independently between the two buffers.
    always_ff @(posedge clk_i) begin
        if (rst_i || start_ok) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            if (wr_last) begin
                wr_sel_q <= ~wr_sel_q;
            end
            if (xfer) begin
                rd_sel_q <= ~rd_sel_q;
            end
        end
    end

    assign wr_full      = wr_sel_q ? full1 : full0;
    assign rd_full      = rd_sel_q ? full1 : full0;
    assign rd_fills_now = wr_last && (wr_sel_q == rd_sel_q);
    assign next_ready   = (rd_sel_q ? full0 : full1) || (wr_last && (wr_sel_q != rd_sel_q));
    assign blk_data_o   = rd_sel_q ? data1 : data0;
`else
    logic [511:0] data0;
    logic         full0;

    sha256_block_buf u_buf0 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (xfer),
        .we_i    (cap_valid_q),
        .widx_i  (cap_idx_q),
        .wdata_i (cap_data),
        .rdata_o (data0),
        .full_o  (full0)
    );

    // Single buffer: the next fill only starts after the transfer frees it.
    assign wr_full      = full0;
    assign rd_full      = full0;
    assign rd_fills_now = wr_last;
    assign next_ready   = 1'b0;
    assign blk_data_o   = data0;
`endif

    // FSM: state register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StFill;
                end
            end
            StFill: begin
                if (rd_full || rd_fills_now) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (blk_ready_i) begin
                    if (out_blk_q == LastBlk) begin
                        state_d = StDone;
                    end else if (!next_ready) begin
                        state_d = StFill;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM: outputs
    always_comb begin
        blk_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        case (state_q)
            StFill: busy_o = 1'b1;
            StHold: begin
                busy_o      = 1'b1;
                blk_valid_o = 1'b1;
            end
            StDone: done_o = 1'b1;
            default: ;
        endcase
        blk_last_o = blk_valid_o && (out_blk_q == LastBlk);
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Self-checking bench: three padders (20, 13 and 14 words) share one memory and a
// behavioural model that rebuilds every expected block from the padding rules.
module tb_sha256_msg_padder;

    localparam int NI = 3;
    localparam int unsigned NW_TAB [NI] = '{20, 13, 14};

    logic         clk = 1'b0;
    logic         rst;
    logic         start    [NI];
    logic [15:0]  in_addr  [NI];
    logic [15:0]  maddr    [NI];
    logic         mrd      [NI];
    logic [31:0]  mdata    [NI];
    logic [511:0] bdata    [NI];
    logic         bvalid   [NI];
    logic         blast    [NI];
    logic         bready   [NI];
    logic         busy     [NI];
    logic         done     [NI];

    logic [31:0]  mem [0:65535];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Model state per instance.
    int           phase   [NI];
    int           blk_idx [NI];
    int           rd_idx  [NI];
    int           ref_cyc [NI];
    bit           seen    [NI];
    int           xfers   [NI];
    logic [15:0]  base    [NI];
    logic [511:0] got      [NI][2];
    logic         got_last [NI][2];
    bit           post_rst = 1'b0;

    sha256_msg_padder #(.NUM_OF_WORDS(20), .MEM_LAT(1)) u_dut20 (
        .clk_i(clk), .rst_i(rst), .start_i(start[0]), .input_addr_i(in_addr[0]),
        .memory_addr_o(maddr[0]), .memory_rd_o(mrd[0]), .memory_read_data_i(mdata[0]),
        .blk_data_o(bdata[0]), .blk_valid_o(bvalid[0]), .blk_last_o(blast[0]),
        .blk_ready_i(bready[0]), .busy_o(busy[0]), .done_o(done[0])
    );

    sha256_msg_padder #(.NUM_OF_WORDS(13), .MEM_LAT(1)) u_dut13 (
        .clk_i(clk), .rst_i(rst), .start_i(start[1]), .input_addr_i(in_addr[1]),
        .memory_addr_o(maddr[1]), .memory_rd_o(mrd[1]), .memory_read_data_i(mdata[1]),
        .blk_data_o(bdata[1]), .blk_valid_o(bvalid[1]), .blk_last_o(blast[1]),
        .blk_ready_i(bready[1]), .busy_o(busy[1]), .done_o(done[1])
    );

    sha256_msg_padder #(.NUM_OF_WORDS(14), .MEM_LAT(1)) u_dut14 (
        .clk_i(clk), .rst_i(rst), .start_i(start[2]), .input_addr_i(in_addr[2]),
        .memory_addr_o(maddr[2]), .memory_rd_o(mrd[2]), .memory_read_data_i(mdata[2]),
        .blk_data_o(bdata[2]), .blk_valid_o(bvalid[2]), .blk_last_o(blast[2]),
        .blk_ready_i(bready[2]), .busy_o(busy[2]), .done_o(done[2])
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < NI; i++) begin
            mdata[i] <= mem[maddr[i]];
        end
    end

    function automatic int unsigned nblk(input int unsigned nw);
        return (nw * 32 + 65 + 511) / 512;
    endfunction

    function automatic logic [31:0] exp_word(input int unsigned nw, input logic [15:0] b,
                                             input int unsigned g);
        logic [15:0] a;
        a = b + 16'(g);
        if (g < nw) return mem[a];
        if (g == nw) return 32'h8000_0000;
        if (g == 16 * nblk(nw) - 1) return 32'(nw * 32);
        return 32'h0;
    endfunction

    function automatic logic [511:0] exp_block(input int unsigned nw, input logic [15:0] b,
                                               input int unsigned k);
        logic [511:0] r;
        for (int w = 0; w < 16; w++) begin
            r[511 - 32 * w -: 32] = exp_word(nw, b, 16 * k + w);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int i, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, i, act, exp);
        end
    endtask

    task automatic chk_blk(input string name, input int i, input logic [511:0] act,
                           input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, i, act, exp);
        end
    endtask

    // Compare process: outputs are sampled on the falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                phase[i] = 0;
            end else begin
                if (post_rst) begin
                    chk("rst_addr", i, 64'(maddr[i]), 64'(0));
                    chk_blk("rst_data", i, bdata[i], 512'(0));
                    chk("rst_last", i, 64'(blast[i]), 64'(0));
                end
                case (phase[i])
                    0: begin
                        chk("idle_outs", i, 64'({bvalid[i], busy[i], done[i], mrd[i]}), 64'(0));
                        if (start[i]) begin
                            phase[i]   = 1;
                            base[i]    = in_addr[i];
                            blk_idx[i] = 0;
                            rd_idx[i]  = 0;
                            ref_cyc[i] = cyc;
                            seen[i]    = 1'b0;
                            xfers[i]   = 0;
                            for (int k = 0; k < 2; k++) begin
                                got[i][k]      = '0;
                                got_last[i][k] = 1'b0;
                            end
                        end
                    end
                    1: begin
                        chk("busy_run", i, 64'({busy[i], done[i]}), 64'(2'b10));
                        if (mrd[i]) begin
                            chk("rd_addr", i, 64'(maddr[i]), 64'(16'(base[i] + 16'(rd_idx[i]))));
                            chk("rd_range", i, 64'(rd_idx[i] < int'(NW_TAB[i])), 64'(1));
                            chk("rd_in_hold", i, 64'(bvalid[i]), 64'(0));
                            rd_idx[i]++;
                        end
                        if (bvalid[i]) begin
                            if (!seen[i]) begin
                                chk("latency", i, 64'(cyc - ref_cyc[i]), 64'(18));
                                seen[i] = 1'b1;
                            end
                            chk_blk("blk_data", i, bdata[i],
                                    exp_block(NW_TAB[i], base[i], blk_idx[i]));
                            chk("blk_last", i, 64'(blast[i]),
                                64'(blk_idx[i] == int'(nblk(NW_TAB[i])) - 1));
                            if (bready[i]) begin
                                if (blk_idx[i] < 2) begin
                                    got[i][blk_idx[i]]      = bdata[i];
                                    got_last[i][blk_idx[i]] = blast[i];
                                end
                                xfers[i]++;
                                ref_cyc[i] = cyc;
                                seen[i]    = 1'b0;
                                if (blk_idx[i] == int'(nblk(NW_TAB[i])) - 1) begin
                                    chk("read_count", i, 64'(rd_idx[i]), 64'(NW_TAB[i]));
                                    phase[i] = 2;
                                end
                                blk_idx[i]++;
                            end
                        end else if (cyc - ref_cyc[i] > 60) begin
                            checks++;
                            failures++;
                            $display("FAIL valid_timeout inst=%0d got=no_valid want=valid", i);
                            phase[i] = 0;
                        end
                    end
                    default: begin
                        chk("done_pulse", i, 64'({bvalid[i], busy[i], done[i]}), 64'(3'b001));
                        phase[i] = 0;
                    end
                endcase
            end
        end
        if (!rst) post_rst = 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input bit v);
        for (int i = 0; i < NI; i++) bready[i] = v;
    endtask

    task automatic pulse_start(input logic [15:0] a0, input logic [15:0] a1,
                               input logic [15:0] a2);
        in_addr[0] = a0;
        in_addr[1] = a1;
        in_addr[2] = a2;
        for (int i = 0; i < NI; i++) start[i] = 1'b1;
        tick();
        for (int i = 0; i < NI; i++) start[i] = 1'b0;
    endtask

    task automatic run_until_idle(input bit rand_ready, input int budget);
        int n;
        n = 0;
        while ((phase[0] != 0 || phase[1] != 0 || phase[2] != 0) && n < budget) begin
            if (rand_ready) begin
                for (int i = 0; i < NI; i++) bready[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
            n++;
        end
        set_ready(1'b1);
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL idle_timeout got=busy want=idle after %0d cycles", n);
        end
    endtask

    task automatic fill_random(input logic [15:0] a);
        for (int j = 0; j < 48; j++) mem[16'(a + 16'(j))] = $urandom;
    endtask

    initial begin : driver
        logic [511:0] e;
        logic [15:0]  ra [NI];
        int           n;

        for (int a = 0; a < 65536; a++) mem[a] = $urandom;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start[i]   = 1'b0;
            in_addr[i] = '0;
            bready[i]  = 1'b1;
            phase[i]   = 0;
        end
        repeat (3) tick();
        rst      = 1'b0;
        post_rst = 1'b1;
        tick();

        // Directed run: mem[0x100 + i] = i + 1.
        for (int j = 0; j < 64; j++) mem[16'h0100 + 16'(j)] = 32'(j + 1);
        pulse_start(16'h0100, 16'h0100, 16'h0100);
        run_until_idle(1'b0, 200);

        e = '0;
        for (int w = 0; w < 16; w++) e[511 - 32 * w -: 32] = 32'(w + 1);
        chk_blk("lit_n20_blk0", 0, got[0][0], e);
        e = '0;
        for (int w = 0; w < 4; w++) e[511 - 32 * w -: 32] = 32'(17 + w);
        e[383:352] = 32'h8000_0000;
        e[31:0]    = 32'h0000_0280;
        chk_blk("lit_n20_blk1", 0, got[0][1], e);
        chk("lit_n20_last", 0, 64'({got_last[0][0], got_last[0][1]}), 64'(2'b01));
        chk("lit_n20_xfers", 0, 64'(xfers[0]), 64'(2));
        e = '0;
        for (int w = 0; w < 13; w++) e[511 - 32 * w -: 32] = 32'(w + 1);
        e[95:64] = 32'h8000_0000;
        e[31:0]  = 32'h0000_01A0;
        chk_blk("lit_n13_blk0", 1, got[1][0], e);
        chk("lit_n13_last", 1, 64'(got_last[1][0]), 64'(1));
        chk("lit_n13_xfers", 1, 64'(xfers[1]), 64'(1));
        e = '0;
        for (int w = 0; w < 14; w++) e[511 - 32 * w -: 32] = 32'(w + 1);
        e[63:32] = 32'h8000_0000;
        chk_blk("lit_n14_blk0", 2, got[2][0], e);
        e = '0;
        e[31:0] = 32'h0000_01C0;
        chk_blk("lit_n14_blk1", 2, got[2][1], e);
        chk("lit_n14_xfers", 2, 64'(xfers[2]), 64'(2));

        // Backpressure on the 20-word instance: 30 cycles without ready.
        bready[0] = 1'b0;
        pulse_start(16'h0100, 16'h0200, 16'h0300);
        n = 0;
        while (!bvalid[0] && n < 40) begin
            tick();
            n++;
        end
        chk("bp_valid_seen", 0, 64'(bvalid[0]), 64'(1));
        repeat (30) tick();
        bready[0] = 1'b1;
        run_until_idle(1'b0, 200);

        // Reset while block 1 is filling, then restart from a fresh region.
        pulse_start(16'h1000, 16'h1000, 16'h1000);
        repeat (22) tick();
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        post_rst = 1'b1;
        tick();
        fill_random(16'h2000);
        pulse_start(16'h2000, 16'h2000, 16'h2000);
        run_until_idle(1'b0, 200);

        // A second start while busy must be ignored.
        fill_random(16'h3000);
        fill_random(16'h4000);
        pulse_start(16'h3000, 16'h3000, 16'h3000);
        repeat (6) tick();
        pulse_start(16'h4000, 16'h4000, 16'h4000);
        run_until_idle(1'b0, 200);

        // Random addresses (including 16-bit wrap), data and ready.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NI; i++) begin
                ra[i] = (it == 0) ? 16'hFFF8 : 16'($urandom);
                fill_random(ra[i]);
            end
            pulse_start(ra[0], ra[1], ra[2]);
            run_until_idle(1'b1, 600);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
